cpu_sequencer: RTL and testbench

- Microcode sequencer for the 8-bit bus CPU.
- Steps T-states fetch → decode → execute, and decodes the 4-bit IR opcode plus ALU flags into the 15-bit control word.
- The control word drives the program counter, MAR, RAM, IR, A/B registers, ALU, output register and flags register on the shared 8-bit bus.
- Adds run/pause/single-step control and halt handling. Sits between the IR/flags and every bus participant.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/cpu_sequencer_microcode_rom.sv | 75 +++++++
 rtl/cpu_sequencer.sv | 95 +++++++++
 tb/tb_cpu_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU sequencer.
// Contents: the control-word bit positions, the opcode encodings, the T-state
// counter width, the sequencer state enum and a helper that builds one-hot
// control bits.
package cpu_pkg;

  localparam int CTRL_W = 15;
  localparam int T_W    = 3;

  // Control-word bit positions, MSB first
  localparam int CE = 14;  // PC increment
  localparam int CO = 13;  // PC out
  localparam int J  = 12;  // PC load
  localparam int MI = 11;  // MAR in
  localparam int RI = 10;  // RAM in
  localparam int RO = 9;   // RAM out
  localparam int II = 8;   // IR in
  localparam int IO = 7;   // IR operand out
  localparam int AI = 6;
  localparam int AO = 5;
  localparam int EO = 4;   // ALU out
  localparam int SU = 3;   // ALU subtract
  localparam int BI = 2;
  localparam int OI = 1;   // output register in
  localparam int FI = 0;   // flags register in

  // Opcodes (IR high nibble)
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_e;

  // One-hot control bit at position idx
  function automatic logic [CTRL_W-1:0] cb(input int idx);
    return CTRL_W'(1) << idx;
  endfunction

endpackage

// File: rtl/cpu_sequencer_microcode_rom.sv
// Combinational microcode ROM.
// Ports:
//   t_state      in  current T-state (0..4)
//   opcode       in  IR high nibble
//   carry_flag   in  registered ALU carry
//   zero_flag    in  registered ALU zero
//   control_word out decoded micro-op bits
//   last_step    out high in the final T-state of the current instruction
module microcode_rom
  import cpu_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic [T_W-1:0]    t_state,
  input  logic [3:0]        opcode,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [CTRL_W-1:0] control_word,
  output logic              last_step
);

  logic [T_W-1:0] last_t;

  // Instruction length; the halt opcode wins over any other decode
  always_comb begin
    last_t = T_W'(2);
    if (opcode != HALT_OPCODE) begin
      case (opcode)
        OP_LDA, OP_STA: last_t = T_W'(3);
        OP_ADD, OP_SUB: last_t = T_W'(4);
        default:        last_t = T_W'(2);
      endcase
    end
  end

  assign last_step = (t_state == last_t);

  always_comb begin
    control_word = '0;
    case (t_state)
      T_W'(0): control_word = cb(CO) | cb(MI);
      T_W'(1): control_word = cb(RO) | cb(II) | cb(CE);
      default: begin
        if (opcode != HALT_OPCODE) begin
          case (opcode)
            OP_LDA: begin
              if (t_state == T_W'(2)) control_word = cb(IO) | cb(MI);
              if (t_state == T_W'(3)) control_word = cb(RO) | cb(AI);
            end
            OP_ADD, OP_SUB: begin
              if (t_state == T_W'(2)) control_word = cb(IO) | cb(MI);
              if (t_state == T_W'(3)) control_word = cb(RO) | cb(BI);
              if (t_state == T_W'(4)) begin
                control_word = cb(EO) | cb(AI) | cb(FI);
                if (opcode == OP_SUB) control_word = control_word | cb(SU);
              end
            end
            OP_STA: begin
              if (t_state == T_W'(2)) control_word = cb(IO) | cb(MI);
              if (t_state == T_W'(3)) control_word = cb(AO) | cb(RI);
            end
            OP_LDI: if (t_state == T_W'(2)) control_word = cb(IO) | cb(AI);
            OP_JMP: if (t_state == T_W'(2)) control_word = cb(IO) | cb(J);
            // Conditional jumps only look at the flags in T2, their last state
            OP_JC:  if (t_state == T_W'(2) && carry_flag) control_word = cb(IO) | cb(J);
            OP_JZ:  if (t_state == T_W'(2) && zero_flag)  control_word = cb(IO) | cb(J);
            OP_OUT: if (t_state == T_W'(2)) control_word = cb(AO) | cb(OI);
            default: control_word = '0;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Microcode sequencer: steps T-states per instruction, handles run/pause,
// single-step and halt, and drives the bus control word from the ROM.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   opcode        IR high nibble (valid from T2)
//   carry_flag    registered ALU carry
//   zero_flag     registered ALU zero
//   run           1 = free-run, 0 = pause at next instruction boundary
//   step          pulse: run one instruction while paused
//   control_word  decoded micro-op bits
//   t_state       current T-state
//   paused        idle at T0 waiting for run/step
//   halted        in HALT (exit only through rst)
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE   = 4'hF,
  parameter bit         START_RUNNING = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic              carry_flag,
  input  logic              zero_flag,
  input  logic              run,
  input  logic              step,
  output logic [CTRL_W-1:0] control_word,
  output logic [T_W-1:0]    t_state,
  output logic              paused,
  output logic              halted
);

  localparam seq_state_e RESET_STATE = START_RUNNING ? ST_RUN : ST_PAUSE;

  seq_state_e        state_q, state_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [CTRL_W-1:0] rom_word;
  logic              last_step;

  microcode_rom #(
    .HALT_OPCODE (HALT_OPCODE)
  ) u_rom (
    .t_state      (t_q),
    .opcode       (opcode),
    .carry_flag   (carry_flag),
    .zero_flag    (zero_flag),
    .control_word (rom_word),
    .last_step    (last_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // A stepped instruction needs no extra flag: run is still low at its
  // boundary, so it naturally falls back into PAUSE.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      ST_RUN: begin
        if (last_step) begin
          t_d = '0;
          if (opcode == HALT_OPCODE) state_d = ST_HALT;
          else if (!run)             state_d = ST_PAUSE;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      ST_PAUSE: begin
        t_d = '0;
        if (run || step) state_d = ST_RUN;
      end
      ST_HALT: t_d = '0;
      default: begin
        state_d = RESET_STATE;
        t_d     = '0;
      end
    endcase
  end

  // Gating with rst keeps the bus quiet while reset is held, even though the
  // reset state itself is RUN/T0 whose ROM word is non-zero.
  assign control_word = (state_q == ST_RUN && !rst) ? rom_word : '0;
  assign t_state      = t_q;
  assign paused       = (state_q == ST_PAUSE);
  assign halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic        carry_flag;
  logic        zero_flag;
  logic        run;
  logic        step;
  logic [14:0] control_word;
  logic [2:0]  t_state;
  logic        paused;
  logic        halted;

  int checks;
  int errors;

  cpu_sequencer #(
    .HALT_OPCODE   (4'hF),
    .START_RUNNING (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .carry_flag   (carry_flag),
    .zero_flag    (zero_flag),
    .run          (run),
    .step         (step),
    .control_word (control_word),
    .t_state      (t_state),
    .paused       (paused),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (control_word !== 15'h0000) begin
      errors++; $display("FAIL reset_word: got %h expected 0000", control_word);
    end
    checks++;
    if (t_state !== 3'd0 || paused !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_state: got t=%0d paused=%b halted=%b expected t=0 paused=0 halted=0",
                         t_state, paused, halted);
    end
    opcode = 4'h2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_add();
    logic [14:0] ew [0:5] = '{15'h2800, 15'h4300, 15'h0880, 15'h0204, 15'h0051, 15'h2800};
    logic [2:0]  et [0:5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (control_word !== ew[i] || t_state !== et[i]) begin
        errors++; $display("FAIL add[%0d]: got word=%h t=%0d expected word=%h t=%0d",
                           i, control_word, t_state, ew[i], et[i]);
      end
    end
  endtask

  task automatic test_ldi();
    logic [14:0] ew [0:3] = '{15'h2800, 15'h4300, 15'h00C0, 15'h2800};
    logic [2:0]  et [0:3] = '{3'd0, 3'd1, 3'd2, 3'd0};
    opcode = 4'h5;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (control_word !== ew[i] || t_state !== et[i]) begin
        errors++; $display("FAIL ldi[%0d]: got word=%h t=%0d expected word=%h t=%0d",
                           i, control_word, t_state, ew[i], et[i]);
      end
    end
  endtask

  task automatic test_jc();
    logic [14:0] t2w [0:1] = '{15'h0000, 15'h1080};
    opcode = 4'h7;
    for (int k = 0; k < 2; k++) begin
      carry_flag = (k == 1);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (control_word !== t2w[k] || t_state !== 3'd2) begin
        errors++; $display("FAIL jc_t2[c=%0d]: got word=%h t=%0d expected word=%h t=2",
                           k, control_word, t_state, t2w[k]);
      end
      @(negedge clk);
      checks++;
      if (t_state !== 3'd0) begin
        errors++; $display("FAIL jc_len[c=%0d]: got t=%0d expected 0", k, t_state);
      end
    end
    carry_flag = 1'b0;
  endtask

  task automatic test_misc_opcodes();
    // opcode, T2 word, T3 word (if any), length, zero flag
    logic [3:0]  op  [0:4] = '{4'h4, 4'hE, 4'h8, 4'h8, 4'h9};
    logic [14:0] w2  [0:4] = '{15'h0880, 15'h0022, 15'h1080, 15'h0000, 15'h0000};
    logic [14:0] w3  [0:4] = '{15'h0420, 15'h0000, 15'h0000, 15'h0000, 15'h0000};
    int          len [0:4] = '{4, 3, 3, 3, 3};
    logic        zf  [0:4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      opcode = op[k];
      zero_flag = zf[k];
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (control_word !== w2[k]) begin
        errors++; $display("FAIL misc_t2[op=%h]: got %h expected %h", op[k], control_word, w2[k]);
      end
      if (len[k] == 4) begin
        @(negedge clk);
        checks++;
        if (control_word !== w3[k]) begin
          errors++; $display("FAIL misc_t3[op=%h]: got %h expected %h", op[k], control_word, w3[k]);
        end
      end
      @(negedge clk);
      checks++;
      if (t_state !== 3'd0) begin
        errors++; $display("FAIL misc_len[op=%h]: got t=%0d expected 0", op[k], t_state);
      end
    end
    zero_flag = 1'b0;
  endtask

  task automatic test_pause_step();
    logic [14:0] ew [0:3] = '{15'h2800, 15'h4300, 15'h0880, 15'h0240};
    opcode = 4'h1;
    run = 1'b1;
    // run drops during T1; LDA must still complete
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) run = 1'b0;
      checks++;
      if (control_word !== ew[i] || t_state !== 3'(i) || paused !== 1'b0) begin
        errors++; $display("FAIL pause_lda[%0d]: got word=%h t=%0d paused=%b expected word=%h t=%0d paused=0",
                           i, control_word, t_state, paused, ew[i], i);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (paused !== 1'b1 || control_word !== 15'h0000 || t_state !== 3'd0) begin
        errors++; $display("FAIL pause_hold[%0d]: got paused=%b word=%h t=%0d expected paused=1 word=0000 t=0",
                           i, paused, control_word, t_state);
      end
    end
    // one step pulse -> exactly one LDA; a step inside it is not queued
    step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      step = (i == 1);
      checks++;
      if (control_word !== ew[i] || t_state !== 3'(i) || paused !== 1'b0) begin
        errors++; $display("FAIL step_lda[%0d]: got word=%h t=%0d paused=%b expected word=%h t=%0d paused=0",
                           i, control_word, t_state, paused, ew[i], i);
      end
    end
    step = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (paused !== 1'b1 || control_word !== 15'h0000 || t_state !== 3'd0) begin
        errors++; $display("FAIL step_repause[%0d]: got paused=%b word=%h t=%0d expected paused=1 word=0000 t=0",
                           i, paused, control_word, t_state);
      end
    end
    run = 1'b1;
    @(negedge clk);
    checks++;
    if (paused !== 1'b0 || control_word !== 15'h2800) begin
      errors++; $display("FAIL resume: got paused=%b word=%h expected paused=0 word=2800", paused, control_word);
    end
  endtask

  task automatic test_halt();
    opcode = 4'hF;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (control_word !== 15'h0000 || t_state !== 3'd2 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_t2: got word=%h t=%0d halted=%b expected word=0000 t=2 halted=0",
                         control_word, t_state, halted);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || paused !== 1'b0 || control_word !== 15'h0000 || t_state !== 3'd0) begin
        errors++; $display("FAIL halt_hold[%0d]: got halted=%b paused=%b word=%h t=%0d expected 1 0 0000 0",
                           i, halted, paused, control_word, t_state);
      end
      run = 1'b1;
      step = i[0];
    end
    step = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0 || t_state !== 3'd0 || control_word !== 15'h0000) begin
      errors++; $display("FAIL halt_rst: got halted=%b t=%0d word=%h expected 0 0 0000",
                         halted, t_state, control_word);
    end
    @(negedge clk);
    opcode = 4'h3;
    rst = 1'b0;
    #1;
    checks++;
    if (control_word !== 15'h2800 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_restart: got word=%h halted=%b expected 2800 0", control_word, halted);
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] ew [0:5] = '{15'h2800, 15'h4300, 15'h0880, 15'h0204, 15'h0059, 15'h2800};
    opcode = 4'h3;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      // a carry change in T3/T4 must not matter
      carry_flag = (i >= 3);
      checks++;
      if (control_word !== ew[i]) begin
        errors++; $display("FAIL sub[%0d]: got %h expected %h", i, control_word, ew[i]);
      end
    end
    carry_flag = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (control_word !== 15'h0204 || t_state !== 3'd3) begin
      errors++; $display("FAIL sub_t3: got word=%h t=%0d expected 0204 3", control_word, t_state);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (control_word !== 15'h0000 || t_state !== 3'd0) begin
      errors++; $display("FAIL async_rst: got word=%h t=%0d expected 0000 0", control_word, t_state);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (control_word !== 15'h2800 || t_state !== 3'd0) begin
      errors++; $display("FAIL post_rst: got word=%h t=%0d expected 2800 0", control_word, t_state);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    opcode = 4'h0;
    carry_flag = 1'b0;
    zero_flag = 1'b0;
    run = 1'b1;
    step = 1'b0;
    test_reset();
    test_add();
    test_ldi();
    test_jc();
    test_misc_opcodes();
    test_pause_step();
    test_halt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
